// File: rtl/imem_decomp_pkg.sv
// imem_decomp_pkg: shared state codes, error constants and default depths
// for the dictionary-decompressing instruction memory.
package imem_decomp_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t IDX  = 2'd1;
    localparam state_t DICT = 2'd2;
    localparam state_t RESP = 2'd3;
    localparam logic [31:0] ERR_WORD = 32'h0000_0000;
    localparam logic [15:0] IDX_ERR = '1;
    localparam int INDEX_DEPTH_DEF = 262144;
    localparam int DICT_DEPTH_DEF = 4096;
    localparam int IDX_W_DEF = 16;
endpackage

// File: rtl/sync_rom.sv
// sync_rom: one-cycle registered-read ROM with a registered out-of-range flag;
// out-of-range reads return FILL.
module sync_rom #(
    parameter int W = 32,
    parameter int DEPTH = 4096,
    parameter int AW = 12,
    parameter logic [W-1:0] FILL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [W-1:0]  rdata,
    output logic          oob
);
    localparam int LW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic hit;
    assign hit = 64'(addr) < 64'(DEPTH);
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            oob   <= 1'b0;
        end else if (en) begin
            rdata <= hit ? mem[addr[LW-1:0]] : FILL;
            oob   <= !hit;
        end
    end
endmodule

// File: rtl/imem_decomp.sv
// imem_decomp: i-cache refill responder decompressing words via index + dictionary ROMs.
// Optional IMEM_DECOMP_STATS_EN adds saturating response/abort counters.
module imem_decomp
    import imem_decomp_pkg::*;
#(
    parameter int INDEX_DEPTH = INDEX_DEPTH_DEF,
    parameter int DICT_DEPTH = DICT_DEPTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        dbg_mem_valid
`ifdef IMEM_DECOMP_STATS_EN
    ,
    output logic [31:0] dbg_resp_count,
    output logic [31:0] dbg_abort_count
`endif
);
    state_t state_q, state_d;
    logic [29:0] word_q, word_d;
    logic err_q, err_d;
    logic [IDX_W-1:0] idx_raw, idx_eff;
    logic idx_oob, dict_oob;
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^mem_addr[1:0];
    // All-ones marker always lands past the dictionary, so the dict ROM flags it.
    assign idx_eff = idx_oob ? '1 : idx_raw;
    sync_rom #(.W(IDX_W), .DEPTH(INDEX_DEPTH), .AW(30)) index_mem (
        .clk(clk), .rst(reset), .en(state_q == IDX), .addr(word_q),
        .rdata(idx_raw), .oob(idx_oob)
    );
    sync_rom #(.W(32), .DEPTH(DICT_DEPTH), .AW(IDX_W), .FILL(ERR_WORD)) dict_mem (
        .clk(clk), .rst(reset), .en(state_q == DICT), .addr(idx_eff),
        .rdata(mem_rdata), .oob(dict_oob)
    );
    always_comb begin
        state_d = state_q == IDLE ? (mem_valid ? IDX : IDLE) :
                  state_q == IDX  ? DICT :
                  state_q == DICT ? RESP : IDLE;
        word_d  = (state_q == IDLE && mem_valid) ? mem_addr[31:2] : word_q;
        err_d   = err_q | (state_q == RESP && dict_oob);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end
    assign mem_ready     = !reset && state_q == RESP && mem_valid;
    assign dbg_mem_valid = !reset && state_q == IDLE && mem_valid;
    assign mem_err       = err_q;
`ifdef IMEM_DECOMP_STATS_EN
    logic [31:0] resp_q, resp_d, abort_q, abort_d;
    always_comb begin
        resp_d  = resp_q + 32'(mem_ready && resp_q != '1);
        abort_d = abort_q + 32'(state_q == RESP && !mem_valid && abort_q != '1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_q  <= '0;
            abort_q <= '0;
        end else begin
            resp_q  <= resp_d;
            abort_q <= abort_d;
        end
    end
    assign dbg_resp_count  = resp_q;
    assign dbg_abort_count = abort_q;
`endif
endmodule

// File: tb/tb_imem_decomp.sv
// tb_imem_decomp: directed and randomized checks of imem_decomp against a
// lookup-table model of the compressed image.
module tb_imem_decomp;
    logic clk = 1'b0, reset = 1'b1, mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic mem_ready, mem_err, dbg_mem_valid;
    logic [31:0] mem_rdata;
`ifdef IMEM_DECOMP_STATS_EN
    logic [31:0] dbg_resp_count, dbg_abort_count;
`endif
    int compared = 0, mismatched = 0, cyc = 0, dbg_n = 0;
    logic [15:0] ref_idx [256];
    logic [31:0] ref_dict [4096];

    imem_decomp dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .dbg_mem_valid(dbg_mem_valid)
`ifdef IMEM_DECOMP_STATS_EN
        , .dbg_resp_count(dbg_resp_count), .dbg_abort_count(dbg_abort_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (dbg_mem_valid) dbg_n <= dbg_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] w = a >> 2;
        if (w >= 32'd262144) return 32'h0;
        if (ref_idx[w[7:0]] >= 16'd4096) return 32'h0;
        return ref_dict[ref_idx[w[7:0]][11:0]];
    endfunction

    task automatic req(input logic [31:0] a, output logic [31:0] rd, output int lat);
        mem_addr = a;
        mem_valid = 1'b1;
        lat = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (mem_ready) break;
        end
        rd = mem_rdata;
        @(posedge clk);
        #1 mem_valid = 1'b0;
    endtask

    task automatic watch_no_ready(input int n, output logic seen);
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rd, a;
        int lat, t0, t_prev, d0;
        logic seen;
        for (int i = 0; i < 4096; i++) begin
            ref_dict[i] = $urandom;
            dut.dict_mem.mem[i] = ref_dict[i];
        end
        for (int i = 0; i < 256; i++) begin
            ref_idx[i] = 16'($urandom_range(0, 4095));
        end
        ref_idx[5] = 16'h0003;
        ref_dict[3] = 32'h0010_0093;
        dut.dict_mem.mem[3] = 32'h0010_0093;
        ref_idx[75] = 16'h1000;
        for (int i = 0; i < 256; i++) dut.index_mem.mem[i] = ref_idx[i];

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'b0, mem_ready}, 32'h0);
        chk("reset_rdata", mem_rdata, 32'h0);
        chk("reset_err", {31'b0, mem_err}, 32'h0);
        chk("reset_dbg", {31'b0, dbg_mem_valid}, 32'h0);
`ifdef IMEM_DECOMP_STATS_EN
        chk("reset_resp_cnt", dbg_resp_count, 32'h0);
        chk("reset_abort_cnt", dbg_abort_count, 32'h0);
`endif
        @(posedge clk);
        #1;

        d0 = dbg_n;
        req(32'h14, rd, lat);
        chk("basic_lat", 32'(lat), 32'd4);
        chk("basic_rdata", rd, 32'h0010_0093);
        chk("basic_err", {31'b0, mem_err}, 32'h0);
        chk("basic_dbg", 32'(dbg_n - d0), 32'd1);

        d0 = dbg_n;
        t_prev = 0;
        mem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_addr = 32'(k * 4);
            lat = 0;
            while (lat < 12) begin
                @(negedge clk);
                lat++;
                if (mem_ready) break;
            end
            t0 = cyc;
            chk($sformatf("b2b_rdata%0d", k), mem_rdata, model_rd(32'(k * 4)));
            if (k > 0) chk($sformatf("b2b_gap%0d", k), 32'(t0 - t_prev), 32'd4);
            t_prev = t0;
            @(posedge clk);
            #1;
        end
        mem_valid = 1'b0;
        chk("b2b_dbg", 32'(dbg_n - d0), 32'd3);

        for (int k = 0; k < 20; k++) begin
            a = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom)};
            if (ref_idx[a[9:2]] >= 16'd4096) a = 32'h14;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            req(a, rd, lat);
            chk($sformatf("rand_lat%0d", k), 32'(lat), 32'd4);
            chk($sformatf("rand_rdata%0d_%h", k, a), rd, model_rd(a));
        end
        chk("rand_err", {31'b0, mem_err}, 32'h0);

        req(32'd75 << 2, rd, lat);
        chk("dictoob_rdata", rd, 32'h0);
        chk("dictoob_err", {31'b0, mem_err}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_clears_err", {31'b0, mem_err}, 32'h0);

        req(32'h0040_0000, rd, lat);
        chk("addroob_lat", 32'(lat), 32'd4);
        chk("addroob_rdata", rd, 32'h0);
        chk("addroob_err", {31'b0, mem_err}, 32'h1);
        repeat (10) @(posedge clk);
        #1;
        chk("addroob_err_sticky", {31'b0, mem_err}, 32'h1);

        mem_addr = 32'h14;
        mem_valid = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        mem_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'b0, mem_ready}, 32'h0);
        chk("midrst_rdata", mem_rdata, 32'h0);
        chk("midrst_err", {31'b0, mem_err}, 32'h0);
        chk("midrst_dbg", {31'b0, dbg_mem_valid}, 32'h0);
        watch_no_ready(6, seen);
        chk("midrst_no_ready", {31'b0, seen}, 32'h0);
        @(posedge clk);
        #1;

        mem_addr = 32'h14;
        mem_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 mem_valid = 1'b0;
        watch_no_ready(6, seen);
        chk("abort_no_ready", {31'b0, seen}, 32'h0);
`ifdef IMEM_DECOMP_STATS_EN
        chk("abort_count", dbg_abort_count, 32'd1);
        chk("abort_resp_count", dbg_resp_count, 32'd0);
`endif
        @(posedge clk);
        #1;

        req(32'h14, rd, lat);
        chk("after_lat", 32'(lat), 32'd4);
        chk("after_rdata", rd, 32'h0010_0093);
        chk("after_err", {31'b0, mem_err}, 32'h0);
`ifdef IMEM_DECOMP_STATS_EN
        chk("after_resp_count", dbg_resp_count, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
